// File: rtl/instr_asm_pkg.sv
// Shared types and constants for the RV32I instruction assembler.
package instr_asm_pkg;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM = 7'h13;
  localparam logic [6:0]  OP     = 7'h33;
  localparam logic [6:0]  STORE  = 7'h23;
  localparam logic [6:0]  BRANCH = 7'h63;
  localparam logic [6:0]  LUI    = 7'h37;
  localparam logic [6:0]  JAL    = 7'h6F;

  typedef struct packed {
    logic [31:0] word;
    logic        err;
  } entry_t;

  // True when every bit of v selected by mask carries the same value.
  function automatic logic all_eq(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == mask) || ((v & mask) == 32'd0);
  endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Field-bundle input and encoded-word output handshakes of the instruction assembler.
interface instr_assembler_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd_addr;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic [2:0]        func3;
  logic [6:0]        func7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [7:0]        err_cnt;

  modport master (
    output in_valid, fmt, opcode, rd_addr, rs1_addr, rs2_addr, func3, func7, imm, out_ready,
    input  in_ready, out_valid, out_word, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, fmt, opcode, rd_addr, rs1_addr, rs2_addr, func3, func7, imm, out_ready,
    output in_ready, out_valid, out_word, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/instr_out_fifo.sv
// Two-entry valid/ready FIFO of encoded entries with synchronous flush.
module instr_out_fifo
  import instr_asm_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_clr,
  input  logic   i_push,
  input  entry_t i_data,
  input  logic   i_pop,
  output logic   o_can_push,
  output logic   o_valid,
  output entry_t o_data
);
  entry_t     r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  assign o_valid    = (r_count != 2'd0);
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
  assign o_can_push = (r_count != 2'd2) || i_pop;
  assign o_data     = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clr) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

endmodule

// File: rtl/instr_assembler.sv
// Packs RV32I field bundles into instruction words and streams them with a word address.
module instr_assembler
  import instr_asm_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input logic               clk,
  input logic               rst,
  input logic               clr,
  instr_assembler_if.slave  bus
);
  fmt_e              w_fmt;
  logic [31:0]       w_imm;
  entry_t            w_enc;
  entry_t            w_head;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_advance;
  logic              w_can_push;
  logic              w_fifo_valid;
  logic              w_pop;
  logic              r_s1_valid;
  entry_t            r_s1;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_err_cnt;

  assign w_fmt = fmt_e'(bus.fmt);
  assign w_imm = bus.imm;

  always_comb begin
    w_enc.word = NOP;
    w_enc.err  = 1'b1;
    case (w_fmt)
      FmtR: begin
        w_enc.word = {bus.func7, bus.rs2_addr, bus.rs1_addr, bus.func3, bus.rd_addr, bus.opcode};
        w_enc.err  = 1'b0;
      end
      FmtI: begin
        w_enc.word = {w_imm[11:0], bus.rs1_addr, bus.func3, bus.rd_addr, bus.opcode};
        w_enc.err  = !all_eq(w_imm, 32'hFFFF_F800);
      end
      FmtS: begin
        w_enc.word = {w_imm[11:5], bus.rs2_addr, bus.rs1_addr, bus.func3, w_imm[4:0], bus.opcode};
        w_enc.err  = !all_eq(w_imm, 32'hFFFF_F800);
      end
      FmtB: begin
        w_enc.word = {w_imm[12], w_imm[10:5], bus.rs2_addr, bus.rs1_addr, bus.func3,
                      w_imm[4:1], w_imm[11], bus.opcode};
        w_enc.err  = !all_eq(w_imm, 32'hFFFF_F000) || w_imm[0];
      end
      FmtU: begin
        w_enc.word = {w_imm[31:12], bus.rd_addr, bus.opcode};
        w_enc.err  = |w_imm[11:0];
      end
      FmtJ: begin
        w_enc.word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.rd_addr, bus.opcode};
        w_enc.err  = !all_eq(w_imm, 32'hFFF0_0000) || w_imm[0];
      end
      default: ;
    endcase
  end

  // clr outranks every transfer: nothing is accepted, advanced or popped that cycle.
  assign w_pop      = w_fifo_valid && bus.out_ready && !clr;
  assign w_advance  = r_s1_valid && w_can_push && !clr;
  assign w_in_ready = !clr && (!r_s1_valid || w_advance);
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (clr) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1       <= w_enc;
    end else if (w_advance) begin
      r_s1_valid <= 1'b0;
    end
  end

  instr_out_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (clr),
    .i_push     (w_advance),
    .i_data     (r_s1),
    .i_pop      (w_pop),
    .o_can_push (w_can_push),
    .o_valid    (w_fifo_valid),
    .o_data     (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_err_cnt <= 8'd0;
    end else begin
      if (clr)        r_addr <= '0;
      else if (w_pop) r_addr <= r_addr + ADDR_W'(1);
      if (w_pop && w_head.err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_fifo_valid;
  assign bus.out_word  = w_head.word;
  assign bus.out_err   = w_head.err;
  assign bus.out_addr  = r_addr;
  assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler with hand-computed expected words and addresses.
module tb_instr_assembler;
  localparam int unsigned AW = 2;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  instr_assembler_if #(.ADDR_W(AW)) bus ();

  instr_assembler #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im);
    bus.fmt = f; bus.opcode = op; bus.rd_addr = rd; bus.rs1_addr = rs1;
    bus.rs2_addr = rs2; bus.func3 = f3; bus.func7 = f7; bus.imm = im;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    set_bundle(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    step(); step();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_word !== 32'd0) begin bad++; $display("FAIL reset_out_word: got %h want 0", bus.out_word); end
    total++; if (bus.out_addr !== 2'd0) begin bad++; $display("FAIL reset_out_addr: got %0d want 0", bus.out_addr); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
    total++; if (bus.err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_i();
    do_reset();
    bus.out_ready = 1'b1;
    set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    bus.in_valid = 1'b1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", bus.out_valid); end
    step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.out_word !== 32'h0050_0093) begin bad++; $display("FAIL single_word: got %h want 00500093", bus.out_word); end
    total++; if (bus.out_addr !== 2'd0) begin bad++; $display("FAIL single_addr: got %0d want 0", bus.out_addr); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", bus.out_err); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drained: got %b want 0", bus.out_valid); end
    total++; if (bus.out_addr !== 2'd1) begin bad++; $display("FAIL single_addr_inc: got %0d want 1", bus.out_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    int k;
    exp_w[0] = 32'h0020_81B3; exp_w[1] = 32'h0020_A423;
    exp_w[2] = 32'hFE00_0EE3; exp_w[3] = 32'h1234_52B7;
    k = 0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: set_bundle(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        1: set_bundle(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        2: set_bundle(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        3: set_bundle(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        default: ;
      endcase
      bus.in_valid = (c < 4);
      if (c < 4) begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, bus.in_ready); end
      end
      if (bus.out_valid === 1'b1) begin
        if (k < 4) begin
          total++;
          if (bus.out_word !== exp_w[k] || bus.out_addr !== 2'(k) || bus.out_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_word[%0d]: got %h@%0d err %b want %h@%0d err 0",
                     k, bus.out_word, bus.out_addr, bus.out_err, exp_w[k], k);
          end
        end
        k++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    total++; if (k != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", k); end
  endtask

  task automatic test_range_errors();
    logic [31:0] exp_w [3];
    int k;
    exp_w[0] = 32'h0020_006F; exp_w[1] = 32'h8000_0013; exp_w[2] = 32'h0000_0013;
    k = 0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: set_bundle(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        1: set_bundle(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        2: set_bundle(3'd7, 7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        default: ;
      endcase
      bus.in_valid = (c < 3);
      if (bus.out_valid === 1'b1) begin
        if (k < 3) begin
          total++;
          if (bus.out_word !== exp_w[k] || bus.out_err !== 1'b1) begin
            bad++;
            $display("FAIL err_word[%0d]: got %h err %b want %h err 1", k, bus.out_word, bus.out_err, exp_w[k]);
          end
        end
        k++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    total++; if (k != 3) begin bad++; $display("FAIL err_count_words: got %0d want 3", k); end
    total++; if (bus.err_cnt !== 8'd3) begin bad++; $display("FAIL err_cnt: got %0d want 3", bus.err_cnt); end
  endtask

  // Runs right after test_range_errors: err_cnt=3 and out_addr=3 on entry.
  task automatic test_clr();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_bundle(3'd1, 7'h13, 5'(c + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(c + 1));
      bus.in_valid = 1'b1;
      step();
    end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL clr_full: got %b want 0", bus.in_ready); end
    set_bundle(3'd1, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    clr = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready: got %b want 0", bus.in_ready); end
    step();
    clr = 1'b0; bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clr_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_addr !== 2'd0) begin bad++; $display("FAIL clr_addr: got %0d want 0", bus.out_addr); end
    total++; if (bus.err_cnt !== 8'd3) begin bad++; $display("FAIL clr_err_cnt: got %0d want 3", bus.err_cnt); end
    step(); step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clr_no_accept: got %b want 0", bus.out_valid); end
    set_bundle(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h0070_0393 || bus.out_addr !== 2'd0) begin
      bad++;
      $display("FAIL clr_next_word: got v%b %h@%0d want v1 00700393@0", bus.out_valid, bus.out_word, bus.out_addr);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [3];
    int nxt;
    int k;
    exp_w[0] = 32'h0010_0093; exp_w[1] = 32'h0020_0113; exp_w[2] = 32'h0030_0193;
    nxt = 0; k = 0;
    do_reset();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (nxt < 5) begin
        set_bundle(3'd1, 7'h13, 5'(nxt + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(nxt + 1));
        bus.in_valid = 1'b1;
      end
      if (bus.in_ready === 1'b1) nxt++;
      step();
    end
    total++; if (nxt != 3) begin bad++; $display("FAIL bp_accepted: got %0d want 3", nxt); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== exp_w[0]) begin
      bad++;
      $display("FAIL bp_head_stable: got v%b %h want v1 %h", bus.out_valid, bus.out_word, exp_w[0]);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid === 1'b1) begin
        if (k < 3) begin
          total++;
          if (bus.out_word !== exp_w[k] || bus.out_addr !== 2'(k)) begin
            bad++;
            $display("FAIL bp_order[%0d]: got %h@%0d want %h@%0d", k, bus.out_word, bus.out_addr, exp_w[k], k);
          end
        end
        k++;
      end
      step();
    end
    total++; if (k != 3) begin bad++; $display("FAIL bp_drained: got %0d want 3", k); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_a [5];
    int k;
    exp_a[0] = 2'd0; exp_a[1] = 2'd1; exp_a[2] = 2'd2; exp_a[3] = 2'd3; exp_a[4] = 2'd0;
    k = 0;
    do_reset();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 5) set_bundle(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'(c));
      bus.in_valid = (c < 5);
      if (bus.out_valid === 1'b1) begin
        if (k < 5) begin
          total++;
          if (bus.out_addr !== exp_a[k] || bus.out_word !== ({12'(k), 20'h0_0013})) begin
            bad++;
            $display("FAIL wrap[%0d]: got %h@%0d want %h@%0d", k, bus.out_word, bus.out_addr,
                     {12'(k), 20'h0_0013}, exp_a[k]);
          end
        end
        k++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    total++; if (k != 5) begin bad++; $display("FAIL wrap_count: got %0d want 5", k); end
  endtask

  task automatic test_async_rst();
    do_reset();
    bus.out_ready = 1'b1;
    set_bundle(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL arst_pre_err_cnt: got %0d want 1", bus.err_cnt); end
    total++; if (bus.out_addr !== 2'd1) begin bad++; $display("FAIL arst_pre_addr: got %0d want 1", bus.out_addr); end
    bus.out_ready = 1'b0;
    set_bundle(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    bus.in_valid = 1'b1;
    step(); step(); step();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid: got %b want 1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_word !== 32'd0 || bus.out_addr !== 2'd0 ||
        bus.out_err !== 1'b0 || bus.err_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL arst_values: got v%b w%h a%0d e%b c%0d r%b want v0 w0 a0 e0 c0 r1",
               bus.out_valid, bus.out_word, bus.out_addr, bus.out_err, bus.err_cnt, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_i();
    test_back_to_back();
    test_range_errors();
    test_clr();
    test_backpressure();
    test_wrap();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_assembler.md
# instr_assembler

Instruction encoder for the RV32I decode path: accepts per-instruction field bundles (opcode, register addresses, func3/func7, immediate, format), packs them into 32-bit instruction words, and streams them with a sequential write address toward instruction memory or a bench loader. It performs the inverse of the field-splitting decode stage, and provides self-generated stimulus for that stage.

## Interface
Parameters:
- ADDR_W, 8, width of the output word address; the address wraps at 2^ADDR_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush: empties the pipeline and FIFO and zeroes the address.
- in_valid  input  1  field bundle is valid.
- in_ready  output  1  block can accept a bundle this cycle.
- fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  input  7  bits [6:0] of the instruction.
- rd_addr  input  5  destination register.
- rs1_addr  input  5  source register 1.
- rs2_addr  input  5  source register 2.
- func3  input  3  function field.
- func7  input  7  function field; used by R format only.
- imm  input  32  byte-level immediate. U format carries the full upper value; B/J carry the byte offset.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head.
- out_word  output  32  encoded instruction.
- out_addr  output  ADDR_W  word index of the head.
- out_err  output  1  head entry had an illegal format or an out-of-range immediate.
- err_cnt  output  8  saturating count of popped entries with the err flag set.

## Operation
- Encoding, MSB to LSB:
  - R: func7|rs2|rs1|func3|rd|opcode.
  - I: imm[11:0]|rs1|func3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|func3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|func3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Range checks; a failure sets err and still emits the truncated encoding:
  - I/S: imm[31:11] must be all-equal.
  - B: imm[31:12] must be all-equal, and imm[0]=0.
  - J: imm[31:20] must be all-equal, and imm[0]=0.
  - U: imm[11:0]=0.
  - R: no check.
- Illegal fmt: word = 32'h0000_0013 (NOP), err=1.
- Pipeline: stage S1 holds the encoded {word, err}; a 2-entry FIFO sits behind it.
- S1 advances into the FIFO when S1 is valid and the FIFO has space (count<2, or a pop occurs in the same cycle).
- in_ready = !clr && (!s1_valid || s1_advance).
- Address counter increments on every pop (out_valid && out_ready) and wraps from 2^ADDR_W-1 to 0. out_addr = counter value.
- err_cnt increments on a pop with out_err=1 and saturates at 255.
- clr has priority over accept, advance and pop in the same cycle: S1 and the FIFO are invalidated and the address is set to 0; err_cnt is kept.

## Timing
- Reset values: in_ready=1, out_valid=0, out_word=0, out_addr=0, out_err=0, err_cnt=0, S1 empty, FIFO empty.
- Latency: a bundle accepted at edge N appears with out_valid=1 after edge N+1 when the FIFO is empty.
- Throughput: 1 word/cycle while out_ready=1.
- The FIFO head is stable while out_valid && !out_ready. out_valid never drops without a pop or clr.
- Full condition (FIFO=2, S1 valid, no pop): in_ready=0. At most 3 words are in flight.
- Simultaneous pop and advance with FIFO full: count stays 2, order is preserved.
- rst asserted mid-stream discards all entries immediately.

## Structure
- Package instr_asm_pkg: fmt_e enum (R/I/S/B/U/J), NOP constant, opcode constants (OP_IMM=7'h13, OP=7'h33, STORE=7'h23, BRANCH=7'h63, LUI=7'h37, JAL=7'h6F), and entry struct {word, err}.
- Sub-module instr_out_fifo: 2-entry valid/ready FIFO of entry struct, with clr.
- Encoder and range check are combinational logic in the top level, feeding S1.

## Test plan
- I format, opcode 13h, rd=1, rs1=0, func3=0, imm=5 -> out_word 0x00500093, out_addr 0, out_err 0, out_valid two cycles after accept.
- Back-to-back R add (rd=3, rs1=1, rs2=2, opcode 33h), S sw (rs1=1, rs2=2, func3=2, imm=8), B beq (imm=-4), U lui (rd=5, imm=0x12345000) -> 0x002081B3, 0x0020A423, 0xFE000EE3, 0x123452B7 at addresses 0..3.
- Range errors: J with imm=3, I with imm=2048, fmt=7 -> out_err=1 on each, NOP word for fmt=7, err_cnt=3.
- Backpressure: hold out_ready=0 and offer 5 bundles -> exactly 3 accepted, in_ready=0, head stable. Release -> words in order at addresses 0,1,2.
- Address wrap with ADDR_W=2: pop 5 words -> out_addr sequence 0,1,2,3,0.
- clr with 3 entries queued and in_valid high -> no accept that cycle, out_valid=0 next cycle, next word at address 0, err_cnt unchanged. Asynchronous rst mid-burst -> all outputs return to their reset values.
